multi_digit_editor: RTL and testbench
=====================================

// Module: multi_digit_editor
// PURPOSE
//  Parametrised successor of the 8-digit hex editor: user edits an N-digit hex value with five
//  push-buttons and sees it on a multiplexed common-anode 7-segment display.
//  Adds a 2-FF input synchroniser, per-button debounce, auto-repeat on up/down, optional
//  selection wrap, selected-digit blink, and exports the edited value for downstream IP.
// PARAMETERS
//  NUM_DIGITS      8          digits on display, 2..16 (need not be a power of two)
//  DEBOUNCE_CYCLES 1000000    cycles a raw level must differ from the stable level before it is accepted
//  SCAN_CYCLES     8192       cycles each digit is driven per refresh
//  REPEAT_DELAY    50000000   cycles up/down must be held before the first auto-repeat
//  REPEAT_RATE     10000000   cycles between subsequent auto-repeat pulses
//  BLINK_CYCLES    25000000   half-period of selected-digit blink; 0 disables blink
//  WRAP_SELECT     0          1: selection wraps at the ends; 0: selection saturates
// PORTS
//  clk        in   1              system clock
//  reset      in   1              asynchronous, active-low reset
//  buttons    in   5              raw buttons: [0] clear, [1] up, [2] select+1, [3] select-1, [4] down
//  segments   out  7              active-low segments {g..a}
//  dot_point  out  1              active-low decimal point
//  anodes     out  NUM_DIGITS     active-low one-cold digit enable
//  value      out  4*NUM_DIGITS   edited value; digit i = value[4i+3:4i]
//  sel        out  $clog2(NUM_DIGITS)  index of the selected digit
// BEHAVIOUR
//  Reset (async assert, sync deassert through the flops):
//   - digits and sel = 0; all counters = 0
//   - segments = 7'b1000000; dot_point = 1; anodes = ~1
//  Conditioning, per button:
//   - 2-FF synchroniser, then debounce counter: counts while sync != stable, clears when equal
//   - at count == DEBOUNCE_CYCLES-1, stable <= sync and the counter clears
//   - press pulse: 1 cycle on each stable 0->1 transition
//   - up/down only: held stable-high for REPEAT_DELAY cycles -> extra pulse, then one every
//     REPEAT_RATE cycles until release; the repeat counter clears on release
//  Command decode, 1 cycle after the pulse:
//   - clear pulse wins over everything: all digits = 0, sel = 0
//   - else exactly one pulse acts; two or more simultaneous non-clear pulses are all ignored
//   - up/down: digit[sel] +/-1 modulo 16 (F->0, 0->F)
//   - select+1 at NUM_DIGITS-1: -> 0 if WRAP_SELECT, else hold; select-1 at 0 symmetric
//  Scan:
//   - prescaler counts 0..SCAN_CYCLES-1; on wrap, scan index advances 0..NUM_DIGITS-1 and wraps
//   - outputs are registered: 1-cycle latency from scan index/digit change to pins
//   - anodes = ~(1<<idx); segments = hex map of digit[idx]
//   - dot_point = 0 iff idx == sel
//   - blink: if BLINK_CYCLES>0, idx==sel and blink phase is off -> segments = 7'h7F (dot_point stays 0)
//   - clear pulse forces segments to the "0" glyph for that cycle
//  value and sel are register outputs that update in the same cycle as the digit store.
// STRUCTURE
//  Package multi_digit_editor_pkg holds:
//   - BTN_CLEAR/UP/RIGHT/LEFT/DOWN index constants
//   - function hex_to_seg(logic [3:0]) returning the active-low glyph
//  Sub-module button_conditioner (sync + debounce + edge + optional repeat; REPEAT_EN param),
//  instantiated 5x; the top holds decode, digit store, scan and blink.
// TESTING  (bench: DEBOUNCE_CYCLES=4, SCAN_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, NUM_DIGITS=5)
//  1. Reset mid-scan -> outputs same cycle: anodes=5'b11110, segments=7'b1000000, dot_point=1, value=0.
//  2. Up glitch of 2 cycles -> no change; up held 10 cycles -> value[3:0]=1 exactly once.
//  3. Up held 31 cycles after accept -> digit0 = 1+1+2 = 4 (press, repeat at 20, repeats at 25 and 30).
//  4. Select+1 x6 with WRAP_SELECT=0 -> sel=4; with WRAP_SELECT=1 -> sel=1. Down on digit 0 -> F.
//  5. Up+select+1 pulses in the same cycle -> no change; clear+up together -> value=0, sel=0.
//  6. Value 20'h0A3F1, sel=2 -> per digit slot: anodes one-cold, glyph matches digit, dot_point=0 on idx 2
//     only, idx 2 blanked during the blink-off phase.

Source files
------------

// File: rtl/multi_digit_editor_pkg.sv
// multi_digit_editor_pkg
//   Shared constants for the multi-digit hex editor: button bit positions,
//   the decoded command type, special segment patterns and the active-low
//   hex-to-7-segment glyph map.
package multi_digit_editor_pkg;

  localparam int BTN_CLEAR = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_DOWN  = 4;
  localparam int NUM_BTN   = 5;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_UP,
    CMD_DOWN,
    CMD_RIGHT,
    CMD_LEFT
  } cmd_t;

  // Active-low glyph, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multi_digit_editor_button_conditioner.sv
// button_conditioner
//   One push-button channel: 2-FF synchroniser, debounce, rising-edge press
//   pulse and, when REPEAT_EN is set, auto-repeat while the button is held.
// Ports
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   raw    in  unsynchronised button level
//   pulse  out one-cycle command pulse (press or auto-repeat)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            s_meta;
  logic            s_sync;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            rep_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= raw;
      s_sync <= s_meta;
    end
  end

  // The raw level has to disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (s_sync == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= s_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stable_d <= 1'b0;
    else        stable_d <= stable;
  end

  assign press = stable & ~stable_d;

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] rep_cnt;
    logic            rep_armed;

    // rep_cnt equals the number of cycles since the level was accepted (or
    // since the last repeat); the first repeat waits REPEAT_DELAY, later
    // ones REPEAT_RATE.
    assign rep_hit = stable &&
                     (rep_armed ? (rep_cnt == RP_W'(REPEAT_RATE))
                                : (rep_cnt == RP_W'(REPEAT_DELAY)));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (!stable) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (rep_hit) begin
        rep_cnt   <= RP_W'(1);
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end else begin : g_no_repeat
    assign rep_hit = 1'b0;
  end

  assign pulse = press | rep_hit;

endmodule

// File: rtl/multi_digit_editor.sv
// multi_digit_editor
//   Edits an N-digit hex value with five push-buttons and shows it on a
//   multiplexed common-anode 7-segment display. The selected digit carries
//   the decimal point and optionally blinks. The edited value is exported.
// Ports
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   buttons    in  raw buttons {down, select-1, select+1, up, clear}
//   segments   out active-low segments {g..a}
//   dot_point  out active-low decimal point
//   anodes     out active-low one-cold digit enable
//   value      out edited value, digit i at [4i+3:4i]
//   sel        out selected digit index
module multi_digit_editor
  import multi_digit_editor_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 8192,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int WRAP_SELECT     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4:0]                    buttons,
  output logic [6:0]                    segments,
  output logic                          dot_point,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic [$clog2(NUM_DIGITS)-1:0] sel
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [NUM_BTN-1:0] pulse;
  cmd_t               cmd;
  logic [VAL_W-1:0]   value_q;
  logic [SEL_W-1:0]   sel_q;
  logic [3:0]         cur_digit;
  logic [SC_W-1:0]    presc;
  logic [SEL_W-1:0]   idx;
  logic [3:0]         scan_digit;
  logic               blink_off;
  logic [6:0]         seg_q;
  logic               dp_q;
  logic [NUM_DIGITS-1:0] anodes_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      ((i == BTN_UP || i == BTN_DOWN) ? 1 : 0),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .raw  (buttons[i]),
      .pulse(pulse[i])
    );
  end

  // Clear beats everything; otherwise only a lone pulse is acted on.
  always_comb begin
    cmd = CMD_NONE;
    if (pulse[BTN_CLEAR]) begin
      cmd = CMD_CLEAR;
    end else begin
      case ({pulse[BTN_DOWN], pulse[BTN_LEFT], pulse[BTN_RIGHT], pulse[BTN_UP]})
        4'b0001: cmd = CMD_UP;
        4'b0010: cmd = CMD_RIGHT;
        4'b0100: cmd = CMD_LEFT;
        4'b1000: cmd = CMD_DOWN;
        default: cmd = CMD_NONE;
      endcase
    end
  end

  assign cur_digit = value_q[{sel_q, 2'b00} +: 4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      sel_q   <= '0;
    end else begin
      case (cmd)
        CMD_CLEAR: begin
          value_q <= '0;
          sel_q   <= '0;
        end
        CMD_UP:   value_q[{sel_q, 2'b00} +: 4] <= cur_digit + 4'd1;
        CMD_DOWN: value_q[{sel_q, 2'b00} +: 4] <= cur_digit - 4'd1;
        CMD_RIGHT: begin
          if (sel_q == SEL_W'(NUM_DIGITS - 1))
            sel_q <= (WRAP_SELECT != 0) ? '0 : sel_q;
          else
            sel_q <= sel_q + 1'b1;
        end
        CMD_LEFT: begin
          if (sel_q == '0)
            sel_q <= (WRAP_SELECT != 0) ? SEL_W'(NUM_DIGITS - 1) : sel_q;
          else
            sel_q <= sel_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == SC_W'(SCAN_CYCLES - 1)) begin
      presc <= '0;
      idx   <= (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  if (BLINK_CYCLES > 0) begin : g_blink
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BL_W-1:0] blink_cnt;
    logic            blink_off_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        blink_cnt   <= '0;
        blink_off_q <= 1'b0;
      end else if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
        blink_cnt   <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end

    assign blink_off = blink_off_q;
  end else begin : g_no_blink
    assign blink_off = 1'b0;
  end

  assign scan_digit = value_q[{idx, 2'b00} +: 4];

  // Pins are registered so anodes, segments and point always change together.
  // A clear shows "0" immediately, matching the store one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anodes_q <= ~NUM_DIGITS'(1);
      seg_q    <= SEG_ZERO;
      dp_q     <= 1'b1;
    end else begin
      anodes_q <= ~(NUM_DIGITS'(1) << idx);
      dp_q     <= (idx != sel_q);
      if (cmd == CMD_CLEAR)
        seg_q <= SEG_ZERO;
      else if (blink_off && (idx == sel_q))
        seg_q <= SEG_BLANK;
      else
        seg_q <= hex_to_seg(scan_digit);
    end
  end

  assign anodes    = anodes_q;
  assign segments  = seg_q;
  assign dot_point = dp_q;
  assign value     = value_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_multi_digit_editor.sv
module tb_multi_digit_editor;

  localparam int K_STATE = 0;
  localparam int K_RESET = 1;
  localparam int K_WSEL  = 2;
  localparam int K_EMPTY = 3;
  localparam int K_SCAN  = 4;

  localparam logic [4:0] B_CLR   = 5'b00001;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b10000;

  localparam logic [19:0] SCAN_VAL = 20'h0A3F1;

  typedef struct {
    logic [19:0] val;
    logic [2:0]  sel;
  } chg_t;

  typedef struct {
    int          kind;
    logic [19:0] val;
    logic [2:0]  sel;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  buttons = 5'b0;
  logic [6:0]  segments, w_segments;
  logic        dot_point, w_dot_point;
  logic [4:0]  anodes, w_anodes;
  logic [19:0] value, w_value;
  logic [2:0]  sel, w_sel;

  chg_t chg_q[$];
  chk_t chk_q[$];
  logic scan_on = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multi_digit_editor #(
    .NUM_DIGITS(5), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_RATE(5), .BLINK_CYCLES(16), .WRAP_SELECT(0)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .segments(segments),
    .dot_point(dot_point), .anodes(anodes), .value(value), .sel(sel)
  );

  multi_digit_editor #(
    .NUM_DIGITS(5), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_RATE(5), .BLINK_CYCLES(16), .WRAP_SELECT(1)
  ) dut_w (
    .clk(clk), .reset(reset), .buttons(buttons), .segments(w_segments),
    .dot_point(w_dot_point), .anodes(w_anodes), .value(w_value), .sel(w_sel)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  // Monitor: pops an expected state whenever the DUT's value/sel changes,
  // and services queued point checks and the scan checks.
  logic [22:0] prev;
  logic        prev_valid = 1'b0;
  chg_t        m_e;
  chk_t        m_c;
  logic        seen_blank, seen_glyph;
  logic [4:0]  idx_seen;
  int          zeros, pos;
  logic [6:0]  exp_seg;
  logic        ok;

  always @(negedge clk) begin
    if (prev_valid && ({value, sel} !== prev)) begin
      total++;
      if (chg_q.size() == 0) begin
        bad++;
        $display("FAIL change: unexpected value=%h sel=%0d", value, sel);
      end else begin
        m_e = chg_q.pop_front();
        if (value !== m_e.val || sel !== m_e.sel) begin
          bad++;
          $display("FAIL change: value=%h sel=%0d want value=%h sel=%0d",
                   value, sel, m_e.val, m_e.sel);
        end
      end
    end
    prev = {value, sel};
    prev_valid = 1'b1;

    while (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      total++;
      case (m_c.kind)
        K_STATE: if (value !== m_c.val || sel !== m_c.sel) begin
          bad++;
          $display("FAIL state: value=%h sel=%0d want value=%h sel=%0d",
                   value, sel, m_c.val, m_c.sel);
        end
        K_RESET: if (anodes !== 5'b11110 || segments !== 7'b1000000 ||
                     dot_point !== 1'b1 || value !== 20'h0 || sel !== 3'd0) begin
          bad++;
          $display("FAIL reset: anodes=%b seg=%b dp=%b value=%h sel=%0d want 11110 1000000 1 00000 0",
                   anodes, segments, dot_point, value, sel);
        end
        K_WSEL: if (w_sel !== m_c.sel) begin
          bad++;
          $display("FAIL wrap_sel: sel=%0d want %0d", w_sel, m_c.sel);
        end
        K_EMPTY: if (chg_q.size() != 0) begin
          bad++;
          $display("FAIL pending: %0d expected changes never seen, want 0", chg_q.size());
        end
        default: if (!(seen_blank && seen_glyph && idx_seen == 5'b11111)) begin
          bad++;
          $display("FAIL scan_cover: blank=%b glyph=%b idx_seen=%b want 1 1 11111",
                   seen_blank, seen_glyph, idx_seen);
        end
      endcase
    end

    if (scan_on) begin
      total++;
      zeros = 0;
      pos = 0;
      for (int i = 0; i < 5; i++) if (anodes[i] == 1'b0) begin zeros++; pos = i; end
      ok = 1'b1;
      exp_seg = glyph(SCAN_VAL[pos*4 +: 4]);
      if (zeros != 1) begin
        ok = 1'b0;
      end else if (pos == 2) begin
        if (dot_point !== 1'b0) ok = 1'b0;
        if (segments === 7'h7F) seen_blank = 1'b1;
        else if (segments === exp_seg) seen_glyph = 1'b1;
        else ok = 1'b0;
      end else begin
        if (dot_point !== 1'b1 || segments !== exp_seg) ok = 1'b0;
      end
      if (zeros == 1) idx_seen[pos] = 1'b1;
      if (!ok) begin
        bad++;
        $display("FAIL scan: anodes=%b seg=%b dp=%b want one-cold, seg=%b (or 1111111 on idx 2), dp=%b",
                 anodes, segments, dot_point, exp_seg, (pos == 2) ? 1'b0 : 1'b1);
      end
    end else begin
      seen_blank = 1'b0;
      seen_glyph = 1'b0;
      idx_seen = 5'b0;
    end
  end

  task automatic press(input logic [4:0] m, input int hold);
    buttons = m;
    repeat (hold) @(posedge clk);
    #1 buttons = 5'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [4:0] m, input logic [19:0] v, input logic [2:0] s);
    chg_q.push_back('{val: v, sel: s});
    press(m, 6);
  endtask

  task automatic check(input int kind, input logic [19:0] v, input logic [2:0] s);
    chk_q.push_back('{kind: kind, val: v, sel: s});
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(K_STATE, 20'h0, 3'd0);

    // Short glitch is rejected, a 10-cycle hold counts once.
    press(B_UP, 2);
    check(K_STATE, 20'h0, 3'd0);
    cmd(B_UP, 20'h00001, 3'd0);
    check(K_STATE, 20'h00001, 3'd0);
    check(K_EMPTY, 20'h0, 3'd0);

    // Asynchronous reset in the middle of a scan slot.
    repeat (7) @(posedge clk);
    chg_q.push_back('{val: 20'h0, sel: 3'd0});
    #2 reset = 1'b0;
    chk_q.push_back('{kind: K_RESET, val: 20'h0, sel: 3'd0});
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 31 cycles held: press, first repeat at 20, then 25 and 30.
    chg_q.push_back('{val: 20'h00001, sel: 3'd0});
    chg_q.push_back('{val: 20'h00002, sel: 3'd0});
    chg_q.push_back('{val: 20'h00003, sel: 3'd0});
    chg_q.push_back('{val: 20'h00004, sel: 3'd0});
    press(B_UP, 31);
    check(K_STATE, 20'h00004, 3'd0);
    check(K_EMPTY, 20'h0, 3'd0);

    // Selection saturates at the top; the wrapping instance comes back to 1.
    for (int i = 1; i <= 4; i++) cmd(B_RIGHT, 20'h00004, 3'(i));
    press(B_RIGHT, 6);
    press(B_RIGHT, 6);
    check(K_STATE, 20'h00004, 3'd4);
    check(K_WSEL, 20'h0, 3'd1);

    cmd(B_CLR, 20'h0, 3'd0);
    check(K_WSEL, 20'h0, 3'd0);
    cmd(B_DOWN, 20'h0000F, 3'd0);
    check(K_STATE, 20'h0000F, 3'd0);

    // Select-1 at 0: holds, wraps to 4 on the other instance.
    press(B_LEFT, 6);
    check(K_STATE, 20'h0000F, 3'd0);
    check(K_WSEL, 20'h0, 3'd4);
    cmd(B_RIGHT, 20'h0000F, 3'd1);
    check(K_WSEL, 20'h0, 3'd0);

    // Simultaneous non-clear pulses are ignored; clear wins over up.
    press(B_UP | B_RIGHT, 6);
    check(K_STATE, 20'h0000F, 3'd1);
    cmd(B_CLR | B_UP, 20'h0, 3'd0);
    check(K_STATE, 20'h0, 3'd0);
    check(K_EMPTY, 20'h0, 3'd0);

    // Build 0A3F1 with digit 2 selected, then watch the display.
    cmd(B_UP, 20'h00001, 3'd0);
    cmd(B_RIGHT, 20'h00001, 3'd1);
    cmd(B_DOWN, 20'h000F1, 3'd1);
    cmd(B_RIGHT, 20'h000F1, 3'd2);
    cmd(B_UP, 20'h001F1, 3'd2);
    cmd(B_UP, 20'h002F1, 3'd2);
    cmd(B_UP, 20'h003F1, 3'd2);
    cmd(B_RIGHT, 20'h003F1, 3'd3);
    for (int i = 0; i < 6; i++) cmd(B_DOWN, {4'h0, 4'(15 - i), 12'h3F1}, 3'd3);
    cmd(B_LEFT, 20'h0A3F1, 3'd2);
    check(K_STATE, SCAN_VAL, 3'd2);

    scan_on = 1'b1;
    repeat (200) @(posedge clk);
    #1 scan_on = 1'b0;
    check(K_SCAN, 20'h0, 3'd0);
    check(K_EMPTY, 20'h0, 3'd0);

    for (int i = 0; i < 20 && chk_q.size() != 0; i++) @(posedge clk);
    if (chk_q.size() != 0) begin
      $display("FAIL drain: %0d checks never serviced, want 0", chk_q.size());
      $fatal(1, "check queue stuck");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
